eeprom_sd_backup: RTL and testbench
===================================

# eeprom_sd_backup

Save-file backup engine between the cartridge EEPROM array and the HPS SD block interface. On image mount it streams the 8 KiB save image from SD into the EEPROM array. On request it streams the array back out to SD. It uses the array's host-side write port and its registered host-side read port, and runs while the EEPROM serial protocol keeps operating.

## Interface
Parameters:
- SECTORS, 16: number of 512-byte sectors; 16 × 512 = 8192 bytes, the full array.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- img_mounted  in  1  level pulse from HPS: image mounted or unmounted
- img_size  in  64  image size in bytes, valid while img_mounted is high
- save_req  in  1  one-cycle request to write the array to SD
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  HPS transfer-active acknowledge
- sd_buff_addr  in  9  byte index within the current sector
- sd_buff_dout  in  8  byte from SD (load)
- sd_buff_wr  in  1  sd_buff_dout valid strobe
- sd_buff_din  out  8  byte to SD (save)
- ee_we  out  1  array write strobe
- ee_write_address  out  13  array write address
- ee_write_data  out  8  array write data
- ee_read_address  out  13  array read address
- ee_read_data  in  8  array read data, registered, 1-cycle latency
- mounted  out  1  a non-empty image is mounted
- busy  out  1  load or save in progress

## Operation
- States: IDLE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER.
- Sector counter `sector` is 4 bits wide.
- `sd_lba` is the zero-extended value of `sector`.
- Mount event: rising edge of img_mounted.
  - If img_size ≠ 0: set mounted=1, set sector=0, go to LOAD_REQ.
  - If img_size = 0: set mounted=0, stay in IDLE.
- A mount event outside IDLE is ignored.
- save_req sets a sticky `save_pending` flag.
- In IDLE with save_pending=1 and mounted=1: clear save_pending, set sector=0, go to SAVE_REQ.
- save_pending is cleared without action when mounted=0.
- LOAD_REQ: sd_rd=1 until sd_ack rises, then sd_rd=0 and go to LOAD_XFER.
- LOAD_XFER, on each sd_buff_wr: ee_we=1, ee_write_address={sector, sd_buff_addr}, ee_write_data=sd_buff_dout. All three are registered.
- LOAD_XFER, on sd_ack falling: if sector=15 go to IDLE, else sector+1 and go to LOAD_REQ.
- SAVE_REQ/SAVE_XFER mirror the load states, using sd_wr instead of sd_rd.
  - ee_read_address={sector, sd_buff_addr}, combinational.
  - sd_buff_din=ee_read_data.
- busy=1 in every state except IDLE.
- Image shorter than 8 KiB: the full 16 sectors are still transferred. Bytes beyond EOF are whatever HPS returns.
- The array host write port has priority over serial-protocol writes. Serial writes during a load may be overwritten; this is accepted.

## Timing
- Reset values:
  - sd_rd=0, sd_wr=0, sd_lba=0, ee_we=0
  - ee_write_address=0, ee_write_data=0
  - mounted=0, busy=0, save_pending=0
  - state=IDLE, sector=0
- sd_buff_din is not reset; it tracks ee_read_data.
- Mount edge detection uses a registered copy of img_mounted.
  - The state change is visible 1 cycle after the edge.
  - sd_rd asserts in that same cycle.
- sd_rd/sd_wr deassert in the cycle after sd_ack is first sampled high.
- ee_we pulses for exactly 1 cycle, 1 cycle after each sd_buff_wr. A 512-byte sector yields 512 pulses.
- Save read path: sd_buff_din is valid 1 clk after sd_buff_addr changes. HPS must hold sd_buff_addr ≥2 clocks per byte.
- Sector advance and the next request are issued 1 cycle after sd_ack falls.
- Simultaneous events in IDLE:
  - Mount edge and save_pending together: load wins and save stays pending. The save starts when the load returns to IDLE.
  - save_req arriving while busy is latched and serviced afterwards.
  - Multiple save_req pulses collapse into one save.
- An asynchronous reset mid-transfer aborts immediately:
  - All outputs return to reset values.
  - A partially loaded array keeps its contents.

## Test plan
- Load: pulse img_mounted with img_size=8192; HPS model returns byte = lba^addr[7:0] for 16 sectors. Required: 8192 ee_we pulses; array[0x1234] = 0x09^0x34 = 0x3D; busy then falls; mounted=1.
- Save: preload array[0x0100]=0xA5, mount, pulse save_req. Required: sd_wr for lba 0..15; HPS captures 0xA5 at lba 0, addr 0x100; busy=0 after sector 15.
- Unmounted save: save_req with mounted=0. Required: sd_wr stays 0, busy stays 0.
- Collision: pulse save_req during a load at sector 5. Required: the load completes all 16 sectors, then exactly one save of lba 0..15 follows.
- Empty mount: img_mounted with img_size=0. Required: mounted=0, no sd_rd.
- Reset: drop reset_n while sd_ack=1 at sector 7. Required: sd_rd=0, busy=0, sector=0 in the same cycle; a new mount restarts at lba 0.

Source files
------------

// File: rtl/eeprom_sd_backup.sv
// eeprom_sd_backup: moves the 8 KiB cartridge save image between the HPS SD
// block interface and the EEPROM array host ports. A mount loads the image
// into the array sector by sector; a save request streams the array back out.
module eeprom_sd_backup #(
  parameter int SECTORS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        save_req,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        ee_we,
  output logic [12:0] ee_write_address,
  output logic [7:0]  ee_write_data,
  output logic [12:0] ee_read_address,
  input  logic [7:0]  ee_read_data,
  output logic        mounted,
  output logic        busy
);

  localparam logic [3:0] LAST_SECTOR = 4'(SECTORS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_XFER,
    SAVE_REQ,
    SAVE_XFER
  } state_t;

  state_t     state, state_next;
  logic [3:0] sector, sector_next;
  logic       mounted_next;
  logic       save_pending, save_pending_next;
  logic       img_mounted_q;
  logic       sd_ack_q;
  logic       mount_edge;
  logic       ack_fall;
  logic       load_byte;

  assign mount_edge = img_mounted & ~img_mounted_q;
  assign ack_fall   = sd_ack_q & ~sd_ack;
  assign load_byte  = (state == LOAD_XFER) && sd_buff_wr;

  // Control registers: FSM state, sector counter, mount/save flags, edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sector        <= 4'd0;
      mounted       <= 1'b0;
      save_pending  <= 1'b0;
      img_mounted_q <= 1'b0;
      sd_ack_q      <= 1'b0;
    end else begin
      state         <= state_next;
      sector        <= sector_next;
      mounted       <= mounted_next;
      save_pending  <= save_pending_next;
      img_mounted_q <= img_mounted;
      sd_ack_q      <= sd_ack;
    end
  end

  // Next-state logic; a mount edge outranks a pending save so the save
  // runs against the freshly loaded image once the load returns to IDLE
  always_comb begin
    state_next        = state;
    sector_next       = sector;
    mounted_next      = mounted;
    save_pending_next = save_pending | save_req;
    case (state)
      IDLE: begin
        if (mount_edge) begin
          if (img_size != 64'd0) begin
            mounted_next = 1'b1;
            sector_next  = 4'd0;
            state_next   = LOAD_REQ;
          end else begin
            mounted_next = 1'b0;
          end
        end else if (save_pending) begin
          // A request arriving in this very cycle stays latched
          save_pending_next = save_req;
          if (mounted) begin
            sector_next = 4'd0;
            state_next  = SAVE_REQ;
          end
        end
      end
      LOAD_REQ: begin
        if (sd_ack) state_next = LOAD_XFER;
      end
      LOAD_XFER: begin
        if (ack_fall) begin
          if (sector == LAST_SECTOR) begin
            state_next = IDLE;
          end else begin
            sector_next = sector + 4'd1;
            state_next  = LOAD_REQ;
          end
        end
      end
      SAVE_REQ: begin
        if (sd_ack) state_next = SAVE_XFER;
      end
      SAVE_XFER: begin
        if (ack_fall) begin
          if (sector == LAST_SECTOR) begin
            state_next = IDLE;
          end else begin
            sector_next = sector + 4'd1;
            state_next  = SAVE_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Array write port: each SD byte strobe becomes one registered write pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ee_we            <= 1'b0;
      ee_write_address <= 13'd0;
      ee_write_data    <= 8'd0;
    end else begin
      ee_we <= load_byte;
      if (load_byte) begin
        ee_write_address <= {sector, sd_buff_addr};
        ee_write_data    <= sd_buff_dout;
      end
    end
  end

  // Requests follow the state directly so they drop the cycle after sd_ack is seen
  assign sd_rd  = (state == LOAD_REQ);
  assign sd_wr  = (state == SAVE_REQ);
  assign busy   = (state != IDLE);
  assign sd_lba = {28'd0, sector};

  // Save path: the array's registered read port supplies the byte one clock later
  assign ee_read_address = {sector, sd_buff_addr};
  assign sd_buff_din     = ee_read_data;

endmodule

// File: tb/tb_eeprom_sd_backup.sv
`timescale 1ns/1ps
module tb_eeprom_sd_backup;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        save_req;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr;
  logic        ee_we;
  logic [12:0] ee_write_address, ee_read_address;
  logic [7:0]  ee_write_data, ee_read_data;
  logic        mounted, busy;

  always #5 clk = ~clk;

  eeprom_sd_backup dut (
    .clk(clk), .reset_n(reset_n), .img_mounted(img_mounted), .img_size(img_size),
    .save_req(save_req), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .ee_we(ee_we), .ee_write_address(ee_write_address),
    .ee_write_data(ee_write_data), .ee_read_address(ee_read_address),
    .ee_read_data(ee_read_data), .mounted(mounted), .busy(busy)
  );

  // EEPROM array model with a backdoor write port for preloading
  logic [7:0]  array_mem [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = 13'd0;
  logic [7:0]  bd_data = 8'd0;
  always @(posedge clk) begin
    if (ee_we) array_mem[ee_write_address] <= ee_write_data;
    else if (bd_we) array_mem[bd_addr] <= bd_data;
    ee_read_data <= array_mem[ee_read_address];
  end

  // Reference model state
  logic [7:0]  ref_img [0:8191];
  logic [4:0]  req_q [$];   // {is_write, lba}
  logic [20:0] wr_q [$];    // {address, data}
  int   checks = 0, failures = 0, we_count = 0;
  bit   model_mounted = 0, owed = 0, abort = 0;
  logic [7:0] cap_0100 = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected requests and array writes as the DUT presents them
  logic       req_prev = 1'b0;
  logic [4:0]  exp_r;
  logic [20:0] exp_w;
  always @(negedge clk) begin
    if (!reset_n) begin
      req_prev <= 1'b0;
    end else begin
      if ((sd_rd | sd_wr) && !req_prev) begin
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected: got rd=%0b wr=%0b lba=%0d, required no request", sd_rd, sd_wr, sd_lba);
        end else begin
          exp_r = req_q.pop_front();
          if (sd_wr !== exp_r[4] || sd_rd !== ~exp_r[4] || sd_lba !== {28'd0, exp_r[3:0]}) begin
            failures++;
            $display("FAIL req_order: got rd=%0b wr=%0b lba=%0d, required wr=%0b lba=%0d",
                     sd_rd, sd_wr, sd_lba, exp_r[4], exp_r[3:0]);
          end
        end
      end
      req_prev <= sd_rd | sd_wr;
      if (ee_we) begin
        we_count++;
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL ee_we_unexpected: got addr=0x%0h data=0x%0h, required no write", ee_write_address, ee_write_data);
        end else begin
          exp_w = wr_q.pop_front();
          if ({ee_write_address, ee_write_data} !== exp_w) begin
            failures++;
            $display("FAIL ee_write: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                     ee_write_address, ee_write_data, exp_w[20:8], exp_w[7:0]);
          end
        end
      end
    end
  end

  // HPS model: serves one sector request (load or save)
  task automatic hps_sector(input bit fixed_pat, output bit done);
    int t;
    bit is_wr;
    logic [3:0] lba;
    logic [7:0] b;
    logic [12:0] ad;
    done = 0;
    t = 0;
    while (!(sd_rd | sd_wr) && t < 300 && !abort) begin
      @(negedge clk);
      t++;
    end
    if (abort) return;
    if (t >= 300) begin
      checks++;
      failures++;
      $display("FAIL hps_request_timeout: no request after %0d cycles, required sd_rd or sd_wr", t);
      return;
    end
    is_wr = sd_wr;
    lba = sd_lba[3:0];
    repeat ($urandom_range(0, 3)) @(negedge clk);
    sd_ack = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 512; a++) begin
      if (abort) begin
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        return;
      end
      ad = {lba, 9'(a)};
      sd_buff_addr = 9'(a);
      if (!is_wr) begin
        b = fixed_pat ? (8'(lba) ^ 8'(a)) : 8'($urandom);
        sd_buff_dout = b;
        sd_buff_wr = 1'b1;
        ref_img[ad] = b;
        wr_q.push_back({ad, b});
        @(negedge clk);
        sd_buff_wr = 1'b0;
        if ($urandom_range(0, 7) == 0) @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
        if (ad == 13'h0100) cap_0100 = sd_buff_din;
        checks++;
        if (sd_buff_din !== ref_img[ad]) begin
          failures++;
          $display("FAIL save_byte: got 0x%0h at lba %0d addr 0x%0h, required 0x%0h", sd_buff_din, lba, a, ref_img[ad]);
        end
      end
    end
    sd_ack = 1'b0;
    if (is_wr && lba == 4'd15) owed = 0;
    done = 1;
    @(negedge clk);
  endtask

  task automatic hps_run(input int n, input bit fixed_pat);
    bit ok;
    for (int i = 0; i < n; i++) begin
      hps_sector(fixed_pat, ok);
      if (!ok) break;
    end
  endtask

  task automatic do_mount(input logic [63:0] size);
    img_size = size;
    img_mounted = 1'b1;
    if (size != 0) begin
      model_mounted = 1;
      for (int s = 0; s < 16; s++) req_q.push_back({1'b0, 4'(s)});
    end else begin
      model_mounted = 0;
    end
    repeat (2) @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic do_save();
    save_req = 1'b1;
    if (model_mounted && !owed) begin
      owed = 1;
      for (int s = 0; s < 16; s++) req_q.push_back({1'b1, 4'(s)});
    end
    @(negedge clk);
    save_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic watch_quiet(input string name, input int n);
    bit act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sd_rd || sd_wr || busy) act = 1;
    end
    chk(name, 64'(act), 64'd0);
  endtask

  initial begin
    int t;
    reset_n = 1'b1; img_mounted = 1'b0; img_size = 64'd0; save_req = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0; sd_buff_wr = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sd_rd", 64'(sd_rd), 0);
    chk("rst_sd_wr", 64'(sd_wr), 0);
    chk("rst_sd_lba", 64'(sd_lba), 0);
    chk("rst_ee_we", 64'(ee_we), 0);
    chk("rst_ee_waddr", 64'(ee_write_address), 0);
    chk("rst_ee_wdata", 64'(ee_write_data), 0);
    chk("rst_mounted", 64'(mounted), 0);
    chk("rst_busy", 64'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Save request before any mount does nothing
    do_save();
    watch_quiet("save_unmounted_idle", 20);

    // Full load with the lba^addr pattern
    we_count = 0;
    do_mount(64'd8192);
    hps_run(16, 1'b1);
    wait_idle("load_busy_falls");
    chk("load_we_count", 64'(we_count), 64'd8192);
    chk("load_array_1234", 64'(array_mem[13'h1234]), 64'h3D);
    chk("load_mounted", 64'(mounted), 64'd1);
    chk("load_queue_empty", 64'(wr_q.size()), 64'd0);

    // Save with a preloaded marker byte
    bd_addr = 13'h0100; bd_data = 8'hA5; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    ref_img[13'h0100] = 8'hA5;
    do_save();
    hps_run(16, 1'b0);
    wait_idle("save_busy_falls");
    chk("save_capture_0100", 64'(cap_0100), 64'hA5);
    chk("save_all_requests", 64'(req_q.size()), 64'd0);

    // Empty mount unmounts; a later save request is dropped
    do_mount(64'd0);
    @(negedge clk);
    chk("empty_mount_mounted", 64'(mounted), 64'd0);
    watch_quiet("empty_mount_no_rd", 10);
    do_save();
    watch_quiet("save_after_unmount", 20);

    // Short image, save requested twice during the load at sector 5
    do_mount(64'd1000);
    fork
      hps_run(32, 1'b0);
      begin
        t = 0;
        while (!(sd_rd && sd_lba == 32'd5) && t < 20000) begin
          @(negedge clk);
          t++;
        end
        chk("collision_reach_sector5", 64'(t < 20000), 64'd1);
        do_save();
        @(negedge clk);
        do_save();
      end
    join
    wait_idle("collision_busy_falls");
    watch_quiet("collision_single_save", 40);
    chk("collision_requests_done", 64'(req_q.size()), 64'd0);

    // Asynchronous reset while sd_ack is high at sector 7
    do_mount(64'd8192);
    fork
      hps_run(16, 1'b0);
      begin
        t = 0;
        do begin
          @(negedge clk);
          #2;
          t++;
        end while (!(sd_ack && sd_rd && sd_lba == 32'd7) && t < 20000);
        chk("reset_reach_sector7", 64'(t < 20000), 64'd1);
        reset_n = 1'b0;
        abort = 1;
        #1;
        chk("reset_sd_rd", 64'(sd_rd), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_sd_lba", 64'(sd_lba), 0);
        chk("reset_mounted", 64'(mounted), 0);
      end
    join
    req_q.delete();
    wr_q.delete();
    model_mounted = 0;
    owed = 0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    abort = 0;
    @(negedge clk);
    do_mount(64'd8192);
    hps_run(16, 1'b0);
    wait_idle("reload_busy_falls");
    chk("reload_mounted", 64'(mounted), 64'd1);
    chk("reload_requests_done", 64'(req_q.size()), 64'd0);
    chk("reload_writes_done", 64'(wr_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
